// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: non-overlapping 1000/0001 serial detector with sample counter.
// Define DET_COUNT_EN to build the saturating per-pattern detection counters.
module seq_pattern_detector #(
    parameter int COUNTER_WIDTH = 8,
    parameter int DET_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     seq_input,
    input  logic                     seq_valid,
    input  logic                     clear,
    output logic                     detect,
    output logic                     pattern_id,
    output logic [COUNTER_WIDTH-1:0] bit_count,
    output logic [DET_CNT_WIDTH-1:0] det_count_1000,
    output logic [DET_CNT_WIDTH-1:0] det_count_0001,
    output logic [2:0]               fsm_state
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, S1 = 3'd1, S10 = 3'd2, S100 = 3'd3,
        S0 = 3'd4, S00 = 3'd5, S000 = 3'd6, S_BAD = 3'd7
    } state_t;

    state_t                   state_q, state_d;
    logic                     detect_q, detect_d;
    logic                     pattern_id_q, pattern_id_d;
    logic [COUNTER_WIDTH-1:0] bit_count_q, bit_count_d;

    always_comb begin
        state_d      = state_q;
        detect_d     = 1'b0;
        pattern_id_d = pattern_id_q;
        bit_count_d  = clear ? '0 : bit_count_q + COUNTER_WIDTH'(seq_valid);
        if (clear || state_q == S_BAD)
            state_d = IDLE;
        else if (seq_valid) begin
            case (state_q)
                IDLE:    state_d = seq_input ? S1 : S0;
                S1:      state_d = seq_input ? S1 : S10;
                S10:     state_d = seq_input ? S1 : S100;
                S100: begin
                    state_d      = seq_input ? S1 : IDLE;
                    detect_d     = ~seq_input;
                    pattern_id_d = seq_input ? pattern_id_q : 1'b0;
                end
                S0:      state_d = seq_input ? S1 : S00;
                S00:     state_d = seq_input ? S1 : S000;
                S000: begin
                    state_d      = seq_input ? IDLE : S000;
                    detect_d     = seq_input;
                    pattern_id_d = seq_input ? 1'b1 : pattern_id_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            detect_q     <= 1'b0;
            pattern_id_q <= 1'b0;
            bit_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            detect_q     <= detect_d;
            pattern_id_q <= pattern_id_d;
            bit_count_q  <= bit_count_d;
        end
    end

`ifdef DET_COUNT_EN
    logic [DET_CNT_WIDTH-1:0] cnt_1000_q, cnt_1000_d, cnt_0001_q, cnt_0001_d;

    always_comb begin
        cnt_1000_d = clear ? '0 :
                     (detect_d && !pattern_id_d && cnt_1000_q != '1) ? cnt_1000_q + DET_CNT_WIDTH'(1) : cnt_1000_q;
        cnt_0001_d = clear ? '0 :
                     (detect_d && pattern_id_d && cnt_0001_q != '1) ? cnt_0001_q + DET_CNT_WIDTH'(1) : cnt_0001_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_1000_q <= '0;
            cnt_0001_q <= '0;
        end else begin
            cnt_1000_q <= cnt_1000_d;
            cnt_0001_q <= cnt_0001_d;
        end
    end

    assign det_count_1000 = cnt_1000_q;
    assign det_count_0001 = cnt_0001_q;
`else
    assign det_count_1000 = '0;
    assign det_count_0001 = '0;
`endif

    assign detect     = detect_q;
    assign pattern_id = pattern_id_q;
    assign bit_count  = bit_count_q;
    assign fsm_state  = state_q;
endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Serial pattern detector consuming the one-bit test stream produced by the sequence generator. Each valid bit advances a 7-state FSM that recognises the 4-bit patterns 1000 and 0001 in non-overlapping mode: the FSM restarts from idle after every detection. Each detection produces a registered one-cycle `detect` pulse tagged with the pattern identity. Optional saturating per-pattern counters give the lab bench a running tally.

## Interface
- `COUNTER_WIDTH`, 8: width of the valid-sample counter `bit_count`.
- `DET_CNT_WIDTH`, 8: width of each per-pattern detection counter.

- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `seq_input`  in  1  serial data bit; sampled only when `seq_valid`=1.
- `seq_valid`  in  1  qualifies `seq_input` on this edge; tie to 1 for a free-running stream.
- `clear`  in  1  synchronous restart; overrides `seq_valid`.
- `detect`  out  1  one-cycle pulse on pattern completion.
- `pattern_id`  out  1  0 = 1000, 1 = 0001; valid while `detect`=1, holds its last value otherwise.
- `bit_count`  out  COUNTER_WIDTH  number of valid samples consumed, modulo 2^COUNTER_WIDTH.
- `det_count_1000`  out  DET_CNT_WIDTH  saturating count of 1000 detections.
- `det_count_0001`  out  DET_CNT_WIDTH  saturating count of 0001 detections.
- `fsm_state`  out  3  current state encoding, for debug.

## Operation
- Encoding: IDLE=0, S1=1, S10=2, S100=3, S0=4, S00=5, S000=6. Code 7 is unused and recovers to IDLE on the next edge.
- Transitions, taken only on edges where `seq_valid`=1 and `clear`=0 (input bit shown after the colon):
  - IDLE: 1 → S1; 0 → S0.
  - S1: 1 → S1; 0 → S10.
  - S10: 1 → S1; 0 → S100.
  - S100: 1 → S1 (1001 is not a match); 0 → IDLE, detect 1000.
  - S0: 1 → S1; 0 → S00.
  - S00: 1 → S1; 0 → S000.
  - S000: 0 → S000 (keeps the three-zero suffix); 1 → IDLE, detect 0001.
- Non-overlapping rule: the bit that completes a pattern is never reused. The next match needs four fresh bits.
- Edge with `seq_valid`=0: state and counters hold; `detect` goes low.
- `bit_count` increments on every valid sample and wraps to 0 past the all-ones value.
- `clear`=1: state goes to IDLE, `bit_count` and both detection counters go to 0, `detect` goes to 0, `pattern_id` holds. The sample on that edge is discarded.
- `reset`: all outputs go to 0 immediately (asynchronously) and the FSM goes to IDLE. A partial pattern is discarded, so `reset` mid-pattern never produces a detection.

## Timing
- `detect` and `pattern_id` are registered. `detect` goes high after the rising edge that samples the final pattern bit and stays high for exactly one cycle.
- Latency: 0 cycles after the sampling edge. A back-to-back detect on the following edge is impossible by construction.
- All counters update on the same edge as the matching `detect`.
- No combinational path from any input to any output.
- With the generator's stream, bit N of its memory reaches this block one edge after the generator's index N. The bench aligns expected values accordingly.

## Configuration
- `DET_COUNT_EN` defined:
  - `det_count_1000` and `det_count_0001` are implemented.
  - Each saturates at 2^DET_CNT_WIDTH−1 and never wraps.
- `DET_COUNT_EN` undefined:
  - Both counter registers are omitted and the ports are driven constant 0.
  - FSM, `detect`, `pattern_id` and `bit_count` behave identically in both builds.

## Test plan
- Reset, then `seq_valid`=1 and stream 1,0,0,0 → `detect`=1 for one cycle after the 4th edge, `pattern_id`=0, `det_count_1000`=1, `bit_count`=4.
- Stream 0,0,0,0,0,1 → exactly one detect, after the 6th bit, `pattern_id`=1. The FSM stays in S000 through the extra zeros.
- Stream 1,0,0,1,0,0,0 → no detect at bit 4 (1001 is rejected); one detect at bit 7, `pattern_id`=0.
- Stream 1,0,0,0,0,0,1 → detect at bit 4 only. Bits 5–7 (0,0,1) must not match, confirming the non-overlap rule.
- Stream 1,0,0,0 with `seq_valid`=0 inserted for 3 cycles between bits 2 and 3 → single detect after the 4th valid bit, `bit_count`=4.
  - Separately: stream 1,0,0, then `reset` pulsed, then 0 → no detect.
  - Separately: stream 1,0,0, then `clear` pulsed, then 0 → no detect.
- With `DET_COUNT_EN` defined and `DET_CNT_WIDTH`=8, send 300 repetitions of 1000 → 300 detect pulses, `det_count_1000`=255, `bit_count`=1200 mod 256 = 176.
  - Undefined build, same stimulus: both detection counters read 0.
